// File: rtl/lte_ul_pd_agc_sched.sv
// rtl/lte_ul_pd_agc_sched.sv - closed-loop uplink AGC measurement and gain-step scheduler
module lte_ul_pd_agc_sched #(
    parameter int              ANT_NUM      = 8,
    parameter int              GW           = 16,
    parameter int              RD_LAT       = 2,
    parameter int              PD_ADDR_BASE = 0,
    parameter logic [GW-1:0]   GAIN_RST     = 16'h4000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_fram_hd,
    input  logic                    i_enable,
    input  logic [7:0]              i_period,
    input  logic [7:0]              i_meas_frames,
    input  logic [31:0]             i_thr_hi,
    input  logic [31:0]             i_thr_lo,
    input  logic [GW-1:0]           i_gain_step,
    input  logic [GW-1:0]           i_gain_min,
    input  logic [GW-1:0]           i_gain_max,
    input  logic [ANT_NUM*GW-1:0]   i_gain_man,
    output logic                    o_pd_trig,
    output logic [7:0]              o_pd_raddr,
    input  logic [31:0]             i_pd_rdata,
    output logic [ANT_NUM*GW-1:0]   o_gain,
    output logic                    o_gain_upd,
    output logic                    o_busy,
    output logic [2:0]              o_state
);

    localparam int VW  = ANT_NUM * GW;
    localparam int RCW = $clog2(ANT_NUM + RD_LAT + 1);
    // Last READ cycle index: the final capture lands RD_LAT cycles after the last address.
    localparam logic [RCW-1:0] RD_LAST   = RCW'(ANT_NUM + RD_LAT - 1);
    localparam logic [RCW-1:0] ADDR_LAST = RCW'(ANT_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRIG  = 3'd1,
        S_MEAS  = 3'd2,
        S_READ  = 3'd3,
        S_CALC  = 3'd4,
        S_APPLY = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       per_cnt, meas_cnt;
    logic [7:0]       per_eff, meas_eff;
    logic             per_hit, meas_hit;
    logic [RCW-1:0]   rd_cnt, rd_cnt_nxt;
    logic [31:0]      pwr [ANT_NUM];
    logic [VW-1:0]    shadow, shadow_calc;
    logic             trig_d, busy_d, upd_d;
    logic [7:0]       raddr_d;

    // A zero period or measurement length behaves as one frame.
    assign per_eff  = (i_period == 8'd0) ? 8'd1 : i_period;
    assign meas_eff = (i_meas_frames == 8'd0) ? 8'd1 : i_meas_frames;
    assign per_hit  = i_fram_hd && (({1'b0, per_cnt} + 9'd1) >= {1'b0, per_eff});
    assign meas_hit = i_fram_hd && (({1'b0, meas_cnt} + 9'd1) >= {1'b0, meas_eff});

    assign o_state = state;

    // One lane's gain step: high power wins over low power, lower clamp then upper clamp.
    function automatic logic [GW-1:0] step_gain(
        input logic [GW-1:0] g,
        input logic [31:0]   p,
        input logic [31:0]   thr_hi,
        input logic [31:0]   thr_lo,
        input logic [GW-1:0] step,
        input logic [GW-1:0] gmin,
        input logic [GW-1:0] gmax
    );
        logic [GW:0]   sum;
        logic [GW-1:0] sub;
        logic [GW-1:0] res;
        sum = {1'b0, g} + {1'b0, step};
        sub = (g > step) ? (g - step) : '0;
        if (p > thr_hi) begin
            res = (sub < gmin) ? gmin : sub;
            res = (res > gmax) ? gmax : res;
        end else if (p < thr_lo) begin
            res = (sum > {1'b0, gmax}) ? gmax : sum[GW-1:0];
        end else begin
            res = g;
        end
        return res;
    endfunction

    // Candidate shadow vector from the captured powers, latched in CALC.
    always_comb begin
        shadow_calc = shadow;
        for (int k = 0; k < ANT_NUM; k++) begin
            shadow_calc[k*GW +: GW] = step_gain(shadow[k*GW +: GW], pwr[k], i_thr_hi, i_thr_lo,
                                                i_gain_step, i_gain_min, i_gain_max);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; manual mode pins the FSM in IDLE.
    always_comb begin
        state_nxt = state;
        if (!i_enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (per_hit) state_nxt = S_TRIG;
                S_TRIG:  state_nxt = S_MEAS;
                S_MEAS:  if (meas_hit) state_nxt = S_READ;
                S_READ:  if (rd_cnt == RD_LAST) state_nxt = S_CALC;
                S_CALC:  state_nxt = S_APPLY;
                S_APPLY: if (i_fram_hd) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and the read sequencer.
    always_comb begin
        trig_d     = (state_nxt == S_TRIG);
        busy_d     = (state_nxt != S_IDLE);
        upd_d      = i_enable && (state == S_APPLY) && i_fram_hd;
        rd_cnt_nxt = ((state == S_READ) && (state_nxt == S_READ)) ? rd_cnt + 1'b1 : '0;
        raddr_d    = o_pd_raddr;
        if ((state_nxt == S_READ) && (rd_cnt_nxt <= ADDR_LAST)) begin
            raddr_d = 8'(PD_ADDR_BASE) + 8'(rd_cnt_nxt);
        end
    end

    // Counters, power capture, shadow gains and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt    <= '0;
            meas_cnt   <= '0;
            rd_cnt     <= '0;
            shadow     <= {ANT_NUM{GAIN_RST}};
            o_gain     <= {ANT_NUM{GAIN_RST}};
            o_pd_trig  <= 1'b0;
            o_pd_raddr <= '0;
            o_gain_upd <= 1'b0;
            o_busy     <= 1'b0;
            for (int k = 0; k < ANT_NUM; k++) begin
                pwr[k] <= '0;
            end
        end else begin
            o_pd_trig  <= trig_d;
            o_pd_raddr <= raddr_d;
            o_gain_upd <= upd_d;
            o_busy     <= busy_d;
            rd_cnt     <= rd_cnt_nxt;
            if (!i_enable) begin
                per_cnt  <= '0;
                meas_cnt <= '0;
                shadow   <= i_gain_man;
                o_gain   <= i_gain_man;
            end else begin
                case (state)
                    S_IDLE:  if (i_fram_hd) per_cnt <= per_hit ? 8'd0 : per_cnt + 8'd1;
                    S_TRIG:  meas_cnt <= '0;
                    S_MEAS:  if (i_fram_hd) meas_cnt <= meas_hit ? 8'd0 : meas_cnt + 8'd1;
                    S_READ: begin
                        for (int k = 0; k < ANT_NUM; k++) begin
                            if (rd_cnt == RCW'(k + RD_LAT)) pwr[k] <= i_pd_rdata;
                        end
                    end
                    S_CALC:  shadow <= shadow_calc;
                    S_APPLY: if (i_fram_hd) o_gain <= shadow;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lte_ul_pd_agc_sched.sv
// tb/tb_lte_ul_pd_agc_sched.sv - scoreboard bench for the uplink AGC scheduler
module tb_lte_ul_pd_agc_sched;

    localparam int ANT = 8;
    localparam int GW  = 16;
    localparam int VW  = ANT * GW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_fram_hd = 1'b0;
    logic           i_enable = 1'b1;
    logic [7:0]     i_period = 8'd2;
    logic [7:0]     i_meas_frames = 8'd1;
    logic [31:0]    i_thr_hi = 32'd500;
    logic [31:0]    i_thr_lo = 32'd100;
    logic [GW-1:0]  i_gain_step = 16'h0100;
    logic [GW-1:0]  i_gain_min = 16'h0000;
    logic [GW-1:0]  i_gain_max = 16'hFFFF;
    logic [VW-1:0]  i_gain_man = '0;
    logic           o_pd_trig;
    logic [7:0]     o_pd_raddr;
    logic [31:0]    i_pd_rdata = '0;
    logic [VW-1:0]  o_gain;
    logic           o_gain_upd;
    logic           o_busy;
    logic [2:0]     o_state;

    always #5 clk = ~clk;

    lte_ul_pd_agc_sched dut (
        .clk(clk), .rst(rst), .i_fram_hd(i_fram_hd), .i_enable(i_enable),
        .i_period(i_period), .i_meas_frames(i_meas_frames),
        .i_thr_hi(i_thr_hi), .i_thr_lo(i_thr_lo), .i_gain_step(i_gain_step),
        .i_gain_min(i_gain_min), .i_gain_max(i_gain_max), .i_gain_man(i_gain_man),
        .o_pd_trig(o_pd_trig), .o_pd_raddr(o_pd_raddr), .i_pd_rdata(i_pd_rdata),
        .o_gain(o_gain), .o_gain_upd(o_gain_upd), .o_busy(o_busy), .o_state(o_state)
    );

    // Power-detect memory with two register stages of read latency.
    logic [31:0] mem [ANT];
    logic [31:0] pd_d1 = '0;
    always @(posedge clk) begin
        pd_d1      <= (o_pd_raddr < 8'd8) ? mem[o_pd_raddr[2:0]] : 32'hDEAD_BEEF;
        i_pd_rdata <= pd_d1;
    end

    int n_cmp = 0;
    int n_err = 0;
    int trig_cnt = 0;
    logic [VW-1:0] exp_q [$];
    logic [7:0]    rd_log [$];
    logic [VW-1:0] mon_e;

    function automatic logic [VW-1:0] rep(input logic [15:0] x);
        return {8{x}};
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expected gain vector on every update pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_pd_trig) trig_cnt++;
            if (o_state == 3'd3) rd_log.push_back(o_pd_raddr);
            if (o_gain_upd) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL upd_unexpected: got pulse with gain %h, required no pulse", o_gain);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (o_gain !== mon_e) begin
                        n_err++;
                        $display("FAIL gain_apply: got %h, required %h", o_gain, mon_e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        i_fram_hd = 1'b1;
        tick(1);
        i_fram_hd = 1'b0;
        tick(1);
    endtask

    task automatic set_manual(input logic [VW-1:0] v);
        i_enable   = 1'b0;
        i_gain_man = v;
        tick(2);
        i_enable   = 1'b1;
    endtask

    task automatic wait_state(input string nm, input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (o_state == s) break;
            tick(1);
        end
        chk(nm, VW'(o_state), VW'(s));
    endtask

    task automatic run_cycle(input string nm, input int nper, input int nmeas,
                             input logic [VW-1:0] g0, input logic [VW-1:0] gexp);
        int t0;
        logic [63:0] addrs;
        t0 = trig_cnt;
        for (int i = 0; i < nper - 1; i++) frame();
        chk({nm, "_notrig_early"}, VW'(trig_cnt), VW'(t0));
        frame();
        chk({nm, "_trig_once"}, VW'(trig_cnt), VW'(t0 + 1));
        rd_log.delete();
        for (int i = 0; i < nmeas; i++) frame();
        wait_state({nm, "_reach_apply"}, 3'd5, 40);
        chk({nm, "_read_cycles"}, VW'(rd_log.size()), VW'(10));
        for (int i = 0; i < 8; i++) addrs[i*8 +: 8] = (i < rd_log.size()) ? rd_log[i] : 8'hFF;
        chk({nm, "_raddr_seq"}, VW'(addrs), VW'(64'h0706050403020100));
        chk({nm, "_hold_before_hdr"}, o_gain, g0);
        exp_q.push_back(gexp);
        frame();
        tick(1);
        chk({nm, "_upd_seen"}, VW'(exp_q.size()), VW'(0));
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < ANT; i++) mem[i] = 32'd1000;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_gain",  o_gain, rep(16'h4000));
        chk("rst_busy",  VW'(o_busy), VW'(0));
        chk("rst_trig",  VW'(o_pd_trig), VW'(0));
        chk("rst_state", VW'(o_state), VW'(0));
        chk("rst_upd",   VW'(o_gain_upd), VW'(0));
        chk("rst_raddr", VW'(o_pd_raddr), VW'(0));

        // Decrease, then decrease limited by gain_min.
        run_cycle("dec", 2, 1, rep(16'h4000), rep(16'h3F00));
        i_gain_min = 16'h3F80;
        run_cycle("clamp_min", 2, 1, rep(16'h3F00), rep(16'h3F80));
        i_gain_min = 16'h0000;

        // Per-lane mix: ordering, capture alignment, threshold edges, unsigned compare.
        set_manual(rep(16'h4000));
        i_gain_step = 16'h0010;
        mem[0] = 32'd50;  mem[1] = 32'd300; mem[2] = 32'd900; mem[3] = 32'd100;
        mem[4] = 32'd500; mem[5] = 32'd501; mem[6] = 32'd99;  mem[7] = 32'hFFFF_FFFF;
        run_cycle("mixed", 2, 1, rep(16'h4000),
                  {16'h3FF0, 16'h4010, 16'h3FF0, 16'h4000, 16'h4000, 16'h3FF0, 16'h4000, 16'h4010});

        // Upper saturation without wrap.
        set_manual(rep(16'hFFF0));
        i_gain_step = 16'h0040;
        for (int i = 0; i < ANT; i++) mem[i] = 32'd50;
        run_cycle("sat_hi", 2, 1, rep(16'hFFF0), rep(16'hFFFF));

        // Lower saturation at zero.
        set_manual(rep(16'h0020));
        for (int i = 0; i < ANT; i++) mem[i] = 32'd1000;
        run_cycle("sat_lo", 2, 1, rep(16'h0020), rep(16'h0000));

        // gain_min above gain_max: upper clamp wins.
        set_manual(rep(16'h4000));
        i_gain_step = 16'h0100;
        i_gain_min  = 16'h5000;
        i_gain_max  = 16'h3000;
        run_cycle("min_gt_max", 2, 1, rep(16'h4000), rep(16'h3000));
        i_gain_min  = 16'h0000;
        i_gain_max  = 16'hFFFF;

        // thr_hi below thr_lo: the high threshold has priority.
        set_manual(rep(16'h4000));
        i_gain_step = 16'h0010;
        i_thr_hi = 32'd100;
        i_thr_lo = 32'd500;
        for (int i = 0; i < ANT; i++) mem[i] = 32'd300;
        run_cycle("thr_prio", 2, 1, rep(16'h4000), rep(16'h3FF0));
        i_thr_hi = 32'd500;
        i_thr_lo = 32'd100;
        i_gain_step = 16'h0100;
        for (int i = 0; i < ANT; i++) mem[i] = 32'd1000;

        // Manual toggle in IDLE clears a partial period count.
        frame();
        i_enable   = 1'b0;
        i_gain_man = rep(16'h4000);
        tick(1);
        i_enable   = 1'b1;
        run_cycle("abort_idle", 2, 1, rep(16'h4000), rep(16'h3F00));

        // Abort during READ.
        frame();
        frame();
        frame();
        chk("abort_in_read", VW'(o_state), VW'(3));
        i_enable   = 1'b0;
        i_gain_man = rep(16'h1234);
        tick(1);
        chk("abort_state", VW'(o_state), VW'(0));
        chk("abort_busy",  VW'(o_busy), VW'(0));
        chk("abort_gain",  o_gain, rep(16'h1234));
        chk("abort_upd",   VW'(o_gain_upd), VW'(0));
        tick(2);
        i_enable = 1'b1;
        run_cycle("abort_read", 2, 1, rep(16'h1234), rep(16'h1134));

        // Zero period / measurement length act as one frame.
        i_period      = 8'd0;
        i_meas_frames = 8'd0;
        run_cycle("zero1", 1, 1, rep(16'h1134), rep(16'h1034));
        run_cycle("zero2", 1, 1, rep(16'h1034), rep(16'h0F34));

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lte_ul_pd_agc_sched.md
Name: lte_ul_pd_agc_sched

Overview:
- Closed-loop uplink AGC scheduler. It sits between the UL power-detect block and the UL per-antenna AGC stage.
- Every I_PERIOD frames it runs one measurement cycle:
  - pulses the power-detect trigger;
  - waits a configured number of frames;
  - reads one power result per antenna over the power-detect read port;
  - steps each antenna's gain up or down against two thresholds.
- Gain updates are applied atomically on a frame header, so the AGC never sees a mixed gain vector inside a frame.

Parameters:
- ANT_NUM, 8, number of antennas (gain lanes).
- GW, 16, width of one gain code.
- RD_LAT, 2, power-detect read latency in clk cycles (address to data).
- PD_ADDR_BASE, 0, read address of antenna 0; antenna k reads at PD_ADDR_BASE+k.
- GAIN_RST, 16'h4000, reset gain code for every antenna.

Ports:
- clk, input, 1, 245.76 MHz datapath clock.
- rst, input, 1, synchronous reset, active-high.
- i_fram_hd, input, 1, 10 ms frame header, one-cycle pulse.
- i_enable, input, 1, 1 = autonomous AGC; 0 = manual mode.
- i_period, input, 8, frames between cycle starts; 0 is treated as 1.
- i_meas_frames, input, 8, frame headers to wait after trigger; 0 is treated as 1.
- i_thr_hi, input, 32, power above this decreases gain.
- i_thr_lo, input, 32, power below this increases gain.
- i_gain_step, input, GW, gain increment/decrement.
- i_gain_min, input, GW, lower gain clamp.
- i_gain_max, input, GW, upper gain clamp.
- i_gain_man, input, ANT_NUM*GW, manual gain vector; antenna 0 in the LSBs.
- o_pd_trig, output, 1, one-cycle trigger to power detect.
- o_pd_raddr, output, 8, power-detect read address.
- i_pd_rdata, input, 32, power-detect read data, valid RD_LAT cycles after the address.
- o_gain, output, ANT_NUM*GW, gain vector to the AGC; antenna 0 in the LSBs.
- o_gain_upd, output, 1, one-cycle pulse on the cycle o_gain changes in auto mode.
- o_busy, output, 1, high in any state other than IDLE.
- o_state, output, 3, current FSM state, for debug.

Behaviour:
- Reset values:
  - o_gain = GAIN_RST in every lane.
  - o_pd_trig = 0, o_pd_raddr = 0, o_gain_upd = 0, o_busy = 0.
  - o_state = IDLE (0); period and measurement counters = 0; shadow gains = GAIN_RST.
- All outputs are registered.
- Manual mode (i_enable=0):
  - FSM is forced to IDLE; counters are cleared.
  - o_gain <= i_gain_man every cycle; shadow <= i_gain_man.
  - o_pd_trig = 0; o_gain_upd = 0.
  - Deasserting i_enable mid-cycle aborts the cycle on the next clock. No partial shadow values reach o_gain.
- FSM states, with encodings:
  - IDLE (0): each i_fram_hd increments the period count. When the count reaches max(i_period,1), the count clears and the FSM goes to TRIG.
  - TRIG (1): o_pd_trig = 1 for exactly one cycle; measurement count cleared; next state MEAS.
  - MEAS (2): counts i_fram_hd. When the count reaches max(i_meas_frames,1), go to READ with k = 0.
  - READ (3):
    - Drive o_pd_raddr = PD_ADDR_BASE+k; capture i_pd_rdata exactly RD_LAT cycles later into lane k.
    - Addresses are issued back-to-back, one per cycle for k = 0..ANT_NUM-1.
    - The state is left after the last capture: ANT_NUM+RD_LAT cycles total.
  - CALC (4): one cycle. For each lane, compute the new shadow gain:
    - If p > i_thr_hi: g' = max(g - step, i_gain_min), with the subtraction saturating at 0 before the clamp.
    - Else if p < i_thr_lo: g' = min(g + step, i_gain_max), computed at GW+1 bits then clamped.
    - Else: g' = g.
    - The i_thr_hi test has priority, covering misconfiguration where thr_hi < thr_lo.
    - Power comparisons are unsigned.
  - APPLY (5): wait for i_fram_hd. On that cycle o_gain <= shadow, o_gain_upd = 1, and the FSM returns to IDLE.
- Frame headers consumed inside states:
  - The APPLY frame header is not counted toward the next period; the period count restarts at 0.
  - A frame header arriving during TRIG, READ or CALC is ignored by all counters.
- Clamp misconfiguration: if i_gain_min > i_gain_max, the result is i_gain_max. The upper clamp is applied last.
- The current gain g is taken from the shadow register, which always equals o_gain outside APPLY.
- Config inputs are sampled live; software changes them only while o_busy = 0.
- Latency, measured from the triggering i_fram_hd: TRIG follows IDLE by 1 cycle.

Test Plan:
- Reset values: assert rst for 3 cycles with i_enable=1 -> o_gain = 0x4000 in all 8 lanes, o_busy=0, o_pd_trig=0, o_state=0.
- Decrease with clamp:
  - Setup: i_period=2, i_meas_frames=1, all rdata=1000, thr_hi=500, thr_lo=100, step=0x100.
  - After 2 frame headers -> exactly one o_pd_trig pulse.
  - After 1 more header -> raddr 0..7 issued on consecutive cycles.
  - Next header -> o_gain = 0x3F00 in all lanes with one o_gain_upd pulse.
  - With gain_min=0x3F80 instead -> o_gain = 0x3F80.
- Mixed per lane: rdata lane0=50, lane1=300, lane2=900, step=0x10 -> lane0 = 0x4010, lane1 = 0x4000, lane2 = 0x3FF0. Checks lane ordering and the RD_LAT=2 capture alignment.
- Saturation:
  - gain=0xFFF0, step=0x40, gain_max=0xFFFF, low power -> 0xFFFF, with no wrap.
  - gain=0x0020, step=0x40, gain_min=0, high power -> 0x0000.
- Abort: drop i_enable during READ -> next cycle o_state=0, o_busy=0, o_gain = i_gain_man, no o_gain_upd pulse. Re-enable -> the period count restarts from 0.
- Zero config: i_period=0, i_meas_frames=0 -> the cycle starts on every frame header, with one frame of measurement wait.
